// File: rtl/regbank_pkg.sv
// Shared types and constants for the register-bank write-back front end.
package regbank_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regbank_writeback_if.sv
// Write-back request handshake: the producer drives valid/address/data, the front end answers with ready.
interface regbank_writeback_if #(
  parameter int DATA_WIDTH = regbank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regbank_pkg::ADDR_WIDTH
);

  logic                  wb_valid;
  logic                  wb_ready;
  logic [ADDR_WIDTH-1:0] wb_address;
  logic [DATA_WIDTH-1:0] wb_data;

  modport master (
    output wb_valid,
    output wb_address,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_address,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/regbank_wb_fifo.sv
// In-order circular write-back queue; exposes every slot with its age so the
// top level can find the youngest pending write to a given address.
module regbank_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  regbank_pkg::wb_entry_t push_entry_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output regbank_pkg::wb_entry_t head_o,
  output logic                  ent_valid_o [DEPTH],
  output regbank_pkg::wb_entry_t ent_o     [DEPTH],
  output logic [$clog2(DEPTH)-1:0] ent_age_o [DEPTH]
);

  import regbank_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q + PTR_W'(do_pop);
    tail_d  = tail_q + PTR_W'(do_push);
    count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; validity comes only from the
  // pointers and count, so resetting them is enough to flush the queue.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= push_entry_i;
    end
  end

  assign head_o = mem_q[head_q];

  // Age 0 is the oldest entry (the head); a slot is live when its age is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_age_o[i]   = PTR_W'(i) - head_q;
      ent_valid_o[i] = ({1'b0, ent_age_o[i]} < count_q);
      ent_o[i]       = mem_q[i];
    end
  end

endmodule

// File: rtl/regbank_writeback.sv
// Write-side front end for the 32 x 64-bit register bank: clears the bank after
// reset, queues write-back requests, drains them one per cycle and forwards pending data to readers.
module regbank_writeback #(
  parameter int DATA_WIDTH = regbank_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regbank_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regbank_writeback_if.slave    wb,
  output logic                  rb_write,
  output logic [ADDR_WIDTH-1:0] rb_address,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic [ADDR_WIDTH-1:0] rd_address1,
  input  logic [ADDR_WIDTH-1:0] rd_address2,
  input  logic [DATA_WIDTH-1:0] bank_data1,
  input  logic [DATA_WIDTH-1:0] bank_data2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  init_done
);

  import regbank_pkg::*;

  localparam int AGE_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_done_q;

  logic       wb_ready;
  logic       push, pop;
  logic       fifo_full, fifo_empty;
  wb_entry_t  push_entry, head;
  logic       ent_valid [DEPTH];
  wb_entry_t  ent       [DEPTH];
  logic [AGE_W-1:0] ent_age [DEPTH];

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] bank_rd [2];
  logic [DATA_WIDTH-1:0] fwd     [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= (state_d == RUN);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    rb_write   = 1'b0;
    rb_address = '0;
    rb_data    = '0;
    wb_ready   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = CLEAR;
      end
      CLEAR: begin
        rb_write   = 1'b1;
        rb_address = clr_cnt_q;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end
      RUN: begin
        wb_ready   = !fifo_full;
        rb_write   = !fifo_empty;
        rb_address = head.addr;
        rb_data    = head.data;
        pop        = !fifo_empty;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wb.wb_ready     = wb_ready;
  assign push            = wb.wb_valid && wb_ready;
  assign push_entry.addr = wb.wb_address;
  assign push_entry.data = wb.wb_data;
  assign init_done       = init_done_q;

  regbank_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .ent_valid_o  (ent_valid),
    .ent_o        (ent),
    .ent_age_o    (ent_age)
  );

  assign rd_addr[0] = rd_address1;
  assign rd_addr[1] = rd_address2;
  assign bank_rd[0] = bank_data1;
  assign bank_rd[1] = bank_data2;

  // Per read port: the youngest live matching entry wins, otherwise the raw bank value.
  always_comb begin : fwd_search
    logic             hit;
    logic [AGE_W-1:0] best_age;
    for (int p = 0; p < 2; p++) begin
      hit      = 1'b0;
      best_age = '0;
      fwd[p]   = bank_rd[p];
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && (ent[i].addr == rd_addr[p]) &&
            (!hit || (ent_age[i] > best_age))) begin
          hit      = 1'b1;
          best_age = ent_age[i];
          fwd[p]   = ent[i].data;
        end
      end
      if (state_q != RUN) begin
        fwd[p] = '0;
      end
    end
  end

  assign rd_data1 = fwd[0];
  assign rd_data2 = fwd[1];

endmodule

// File: tb/tb_regbank_writeback.sv
// Self-checking bench for regbank_writeback with a behavioural bank and a write-port scoreboard.
module tb_regbank_writeback;

  import regbank_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_writeback_if wb_if ();

  logic          rb_write;
  logic [AW-1:0] rb_address;
  logic [DW-1:0] rb_data;
  logic [AW-1:0] rd_address1, rd_address2;
  logic [DW-1:0] bank_data1, bank_data2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          init_done;

  regbank_writeback #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb_if.slave),
    .rb_write    (rb_write),
    .rb_address  (rb_address),
    .rb_data     (rb_data),
    .rd_address1 (rd_address1),
    .rd_address2 (rd_address2),
    .bank_data1  (bank_data1),
    .bank_data2  (bank_data2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .init_done   (init_done)
  );

  // Behavioural bank: unreset storage, one write port, two asynchronous read ports.
  logic [DW-1:0] bank_mem [NUM_REGS];
  always @(posedge clk) begin
    if (rb_write) bank_mem[rb_address] <= rb_data;
  end
  assign bank_data1 = bank_mem[rd_address1];
  assign bank_data2 = bank_mem[rd_address2];

  int        checks   = 0;
  int        failures = 0;
  int        rb_writes = 0;
  wb_entry_t exp_q [$];
  wb_entry_t mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every bank write must match the next expected entry, in order.
  always @(negedge clk) begin
    if (rst_n && rb_write) begin
      rb_writes++;
      if (exp_q.size() == 0) begin
        check("rb_unexpected", {63'b0, rb_write}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rb_address", {59'b0, rb_address}, {59'b0, mon_e.addr});
        check("rb_data", rb_data, mon_e.data);
      end
    end
  end

  task automatic push_clear_expect();
    wb_entry_t e;
    for (int i = 0; i < NUM_REGS; i++) begin
      e.addr = AW'(i);
      e.data = '0;
      exp_q.push_back(e);
    end
  endtask

  // Drive one request and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
    logic      rdy;
    logic      accepted;
    wb_entry_t e;
    wb_if.wb_valid   = 1'b1;
    wb_if.wb_address = a;
    wb_if.wb_data    = d;
    waited   = 0;
    accepted = 1'b0;
    while (!accepted && waited < 100) begin
      @(negedge clk);
      rdy = wb_if.wb_ready;
      @(posedge clk);
      if (rdy) begin
        accepted = 1'b1;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
      end else begin
        waited++;
      end
    end
    #1;
    check("accept", {63'b0, accepted}, 64'd1);
  endtask

  task automatic wait_clear_done();
    repeat (32) @(posedge clk);
    #1;
    check("init_done_before_33", {63'b0, init_done}, 64'd0);
    check("rd_data1_in_clear", rd_data1, 64'd0);
    @(posedge clk);
    #1;
    check("init_done_at_33", {63'b0, init_done}, 64'd1);
    check("wb_ready_at_33", {63'b0, wb_if.wb_ready}, 64'd1);
    check("clear_write_count", rb_writes, 32);
  endtask

  initial begin
    int            w;
    logic [AW-1:0] s_addr [8];
    logic [DW-1:0] s_data [8];

    for (int i = 0; i < NUM_REGS; i++) bank_mem[i] = {$urandom, $urandom} | 64'h1;
    wb_if.wb_valid   = 1'b0;
    wb_if.wb_address = '0;
    wb_if.wb_data    = '0;
    rd_address1      = AW'(31);
    rd_address2      = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_ready", {63'b0, wb_if.wb_ready}, 64'd0);
    check("rst_rb_write", {63'b0, rb_write}, 64'd0);
    check("rst_rb_address", {59'b0, rb_address}, 64'd0);
    check("rst_rb_data", rb_data, 64'd0);
    check("rst_init_done", {63'b0, init_done}, 64'd0);
    check("rst_rd_data1", rd_data1, 64'd0);
    check("rst_rd_data2", rd_data2, 64'd0);

    // Release; requests offered during CLEAR must be refused
    @(negedge clk);
    rst_n = 1'b1;
    push_clear_expect();
    rb_writes = 0;
    @(posedge clk);
    #1;
    wb_if.wb_valid   = 1'b1;
    wb_if.wb_address = AW'(9);
    wb_if.wb_data    = 64'h0BAD_0BAD_0BAD_0BAD;
    repeat (30) begin
      @(negedge clk);
      check("ready_in_clear", {63'b0, wb_if.wb_ready}, 64'd0);
    end
    wb_if.wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("init_done_before_33", {63'b0, init_done}, 64'd0);
    check("rd_data1_in_clear", rd_data1, 64'd0);
    @(posedge clk);
    #1;
    check("init_done_at_33", {63'b0, init_done}, 64'd1);
    check("wb_ready_at_33", {63'b0, wb_if.wb_ready}, 64'd1);
    check("clear_write_count", rb_writes, 32);
    check("sb_after_clear", exp_q.size(), 0);

    for (int i = 0; i < NUM_REGS; i++) begin
      rd_address1 = AW'(i);
      rd_address2 = AW'(NUM_REGS - 1 - i);
      #1;
      check("bank_zero_p1", rd_data1, 64'd0);
      check("bank_zero_p2", rd_data2, 64'd0);
    end
    @(posedge clk);
    #1;

    // Single write: forwarded from the accept edge, in the bank one edge later
    rd_address1 = AW'(5);
    send(AW'(5), 64'hDEAD_BEEF_0000_0001, w);
    wb_if.wb_valid = 1'b0;
    #1;
    check("single_fwd", rd_data1, 64'hDEAD_BEEF_0000_0001);
    check("single_bank_stale", bank_data1, 64'd0);
    check("single_rb_write", {63'b0, rb_write}, 64'd1);
    @(posedge clk);
    #1;
    check("single_bank_new", bank_data1, 64'hDEAD_BEEF_0000_0001);
    check("single_rd_after", rd_data1, 64'hDEAD_BEEF_0000_0001);
    check("single_drained", {63'b0, rb_write}, 64'd0);

    // Back-to-back duplicates to address 7: youngest value visible each cycle
    rd_address2 = AW'(7);
    send(AW'(7), 64'd1, w);
    check("b2b_wait1", w, 0);
    check("b2b_fwd1", rd_data2, 64'd1);
    send(AW'(7), 64'd2, w);
    check("b2b_wait2", w, 0);
    check("b2b_fwd2", rd_data2, 64'd2);
    send(AW'(7), 64'd3, w);
    wb_if.wb_valid = 1'b0;
    check("b2b_wait3", w, 0);
    check("b2b_fwd3", rd_data2, 64'd3);
    @(posedge clk);
    #1;
    check("b2b_bank_final", bank_data2, 64'd3);
    check("b2b_drained", {63'b0, rb_write}, 64'd0);

    // Sustained stream, including register 0, with no bubbles
    for (int k = 0; k < 8; k++) begin
      s_addr[k] = AW'((k * 9) % NUM_REGS);
      s_data[k] = {$urandom, $urandom};
      send(s_addr[k], s_data[k], w);
      check("stream_wait", w, 0);
      rd_address1 = s_addr[k];
      #1;
      check("stream_fwd", rd_data1, s_data[k]);
    end
    wb_if.wb_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      rd_address1 = s_addr[k];
      #1;
      check("stream_bank", bank_data1, s_data[k]);
    end
    check("sb_after_stream", exp_q.size(), 0);

    // Reset with a write pending: it must never reach the bank
    @(posedge clk);
    #1;
    rd_address1 = AW'(12);
    send(AW'(12), 64'h1234_5678_9ABC_DEF0, w);
    rst_n = 1'b0;
    wb_if.wb_valid = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_rb_write", {63'b0, rb_write}, 64'd0);
    check("mid_rst_wb_ready", {63'b0, wb_if.wb_ready}, 64'd0);
    check("mid_rst_init_done", {63'b0, init_done}, 64'd0);
    check("mid_rst_rd_data1", rd_data1, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_discarded", bank_data1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_clear_expect();
    rb_writes = 0;
    wait_clear_done();
    check("flush_no_leftover", {63'b0, rb_write}, 64'd0);
    @(posedge clk);
    #1;
    check("flush_idle_after", {63'b0, rb_write}, 64'd0);
    check("sb_final", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
